uart_rx: RTL and testbench

Oversampling UART receiver for the UART IP. Consumes the 16x-oversample tick from the baud rate generator, synchronizes the serial input, locates the start bit, samples each bit at mid-period, and delivers the frame LSB first. Output is a one-entry holding register with a valid/ready handshake, plus parity, framing and overrun status. Sits between the pad-side serial input and the register/FIFO interface.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_rx_sync.sv | 23 ++
 rtl/uart_rx.sv | 101 ++++++++++
 tb/tb_uart_rx.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and widths for the receiver and transmitter
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
  localparam int DATA_BITS_DEF = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int BIT_CNT_W = 4;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line plus falling-edge detect
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rx,
  output logic o_level,
  output logic o_fall
);
  logic s1, s2, prev;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1 <= i_rx;
      s2 <= s1;
      prev <= s2;
    end
  end
  assign o_level = s2;
  assign o_fall = prev & ~s2;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with one-entry holding register and error status
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_stick,
  input  logic                 i_rx,
  input  logic                 i_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  rx_state_e state;
  logic [CW-1:0] cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic perr, level, fall;
  uart_rx_sync sync (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_rx(i_rx),
    .o_level(level),
    .o_fall(fall)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      perr <= 1'b0;
      o_data <= '0;
      o_valid <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun <= 1'b0;
      o_busy <= 1'b0;
    end else begin
      o_overrun <= 1'b0;
      if (o_valid && i_ready) o_valid <= 1'b0;
      case (state)
        IDLE: if (fall) begin
          state <= START;
          cnt <= '0;
          o_busy <= 1'b1;
        end
        START: if (i_stick) begin
          if (cnt == HALF) begin
            // a start bit that is high again at mid-bit was a glitch
            state <= level ? IDLE : DATA;
            o_busy <= ~level;
            cnt <= '0;
            bit_cnt <= '0;
            perr <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        DATA: if (i_stick) begin
          if (cnt == LAST) begin
            cnt <= '0;
            shreg <= {level, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) state <= (PARITY_EN != 0) ? PARITY : STOP;
          end else cnt <= cnt + 1'b1;
        end
        PARITY: if (i_stick) begin
          if (cnt == LAST) begin
            cnt <= '0;
            perr <= (^shreg ^ level) != 1'(PARITY_ODD);
            state <= STOP;
          end else cnt <= cnt + 1'b1;
        end
        STOP: if (i_stick) begin
          if (cnt == LAST) begin
            cnt <= '0;
            state <= IDLE;
            o_busy <= 1'b0;
            if (!o_valid || i_ready) begin
              o_data <= shreg;
              o_parity_err <= perr;
              o_frame_err <= ~level;
              o_valid <= 1'b1;
            end else o_overrun <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames on 8N1 and 8E1 receivers sharing one line
module tb_uart_rx;
  typedef struct {
    logic [7:0] d;
    logic p;
    logic f;
  } rec_t;
  logic clk = 1'b0, rst = 1'b1, stick = 1'b0, rx = 1'b1, rdy = 1'b1;
  logic [1:0] sc = 2'd0;
  logic [7:0] d0, dp;
  logic v0, pe0, fe0, ov0, busy0, vp, pep, fep, ovp, busyp;
  rec_t q0[$], qp[$];
  int vcyc = 0, ovr = 0, bcyc = 0, tests = 0, fails = 0;
  uart_rx dut (
    .i_clk(clk), .i_rst(rst), .i_stick(stick), .i_rx(rx), .i_ready(rdy),
    .o_data(d0), .o_valid(v0), .o_parity_err(pe0), .o_frame_err(fe0),
    .o_overrun(ov0), .o_busy(busy0)
  );
  uart_rx #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .i_clk(clk), .i_rst(rst), .i_stick(stick), .i_rx(rx), .i_ready(rdy),
    .o_data(dp), .o_valid(vp), .o_parity_err(pep), .o_frame_err(fep),
    .o_overrun(ovp), .o_busy(busyp)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    sc <= sc + 2'd1;
    stick <= (sc == 2'd3);
  end
  always @(negedge clk) begin
    if (v0 && rdy) q0.push_back('{d0, pe0, fe0});
    if (vp && rdy) qp.push_back('{dp, pep, fep});
    if (v0) vcyc++;
    if (ov0) ovr++;
    if (busy0) bcyc++;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] d, input bit par, input logic pb, input logic stop);
    rx = 1'b0;
    tick(64);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(64);
    end
    if (par) begin
      rx = pb;
      tick(64);
    end
    rx = stop;
    tick(64);
    rx = 1'b1;
    tick(128);
  endtask
  task automatic chk_rec(input string tag, input bit sel, input int base,
                         input logic [7:0] d, input logic p, input logic f);
    rec_t r;
    int n;
    n = sel ? qp.size() : q0.size();
    chk({tag, "_cnt"}, n, base + 1);
    r.d = 'x;
    r.p = 'x;
    r.f = 'x;
    if (n > base) r = sel ? qp[base] : q0[base];
    chk({tag, "_data"}, r.d, d);
    chk({tag, "_perr"}, r.p, p);
    chk({tag, "_ferr"}, r.f, f);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, v0, 0);
    chk({tag, "_data"}, d0, 0);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_ovr"}, ov0, 0);
    chk({tag, "_errs"}, {pe0, fe0}, 0);
    chk({tag, "_p_valid"}, {vp, dp, busyp, pep, fep}, 0);
  endtask
  initial begin
    int b0, bp, v, o, bb;
    logic [7:0] d;
    logic s, pb;
    tick(5);
    chk_zero("reset");
    rst = 1'b0;
    tick(20);
    b0 = q0.size();
    v = vcyc;
    send(8'hA5, 0, 0, 1);
    chk_rec("a5", 0, b0, 8'hA5, 0, 0);
    chk("a5_valid_cycles", vcyc - v, 1);
    bp = qp.size();
    send(8'h07, 1, 0, 1);
    chk_rec("par07_bad", 1, bp, 8'h07, 1, 0);
    bp = qp.size();
    send(8'h07, 1, 1, 1);
    chk_rec("par07_good", 1, bp, 8'h07, 0, 0);
    b0 = q0.size();
    send(8'h3C, 0, 0, 0);
    chk_rec("frame3c", 0, b0, 8'h3C, 0, 1);
    b0 = q0.size();
    send(8'h55, 0, 0, 1);
    chk_rec("after_ferr55", 0, b0, 8'h55, 0, 0);
    v = vcyc;
    bb = bcyc;
    rx = 1'b0;
    tick(20);
    rx = 1'b1;
    tick(44);
    chk("glitch_busy_seen", (bcyc - bb) > 0, 1);
    chk("glitch_busy_low", busy0, 0);
    chk("glitch_no_valid", vcyc - v, 0);
    b0 = q0.size();
    o = ovr;
    rdy = 1'b0;
    send(8'h11, 0, 0, 1);
    send(8'h22, 0, 0, 1);
    chk("ovr_valid", v0, 1);
    chk("ovr_data", d0, 8'h11);
    chk("ovr_pulses", ovr - o, 1);
    rdy = 1'b1;
    tick(1);
    chk("ovr_cleared", v0, 0);
    chk_rec("ovr_accept", 0, b0, 8'h11, 0, 0);
    rx = 1'b0;
    tick(64);
    rx = 1'b1;
    tick(192);
    rst = 1'b1;
    tick(2);
    chk_zero("midrst");
    rst = 1'b0;
    tick(400);
    b0 = q0.size();
    send(8'h81, 0, 0, 1);
    chk_rec("after_rst81", 0, b0, 8'h81, 0, 0);
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      b0 = q0.size();
      send(d, 0, 0, s);
      chk_rec($sformatf("rnd8n1_%0d", i), 0, b0, d, 0, ~s);
    end
    for (int i = 0; i < 10; i++) begin
      d = 8'($urandom);
      pb = 1'($urandom_range(0, 1));
      bp = qp.size();
      send(d, 1, pb, 1);
      chk_rec($sformatf("rnd8e1_%0d", i), 1, bp, d, ($countones(d) + pb) % 2 != 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
